cvxif_copro_responder: RTL and testbench

CVXIF_COPRO_RESPONDER -- requirements
Module: cvxif_copro_responder

---
 rtl/cvxif_copro_responder_if.sv | 43 ++++
 rtl/cvxif_copro_responder.sv | 190 +++++++++++++++++++
 tb/tb_cvxif_copro_responder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cvxif_copro_responder_if.sv
// CV-X-IF style issue / commit / result bundle between a core and a coprocessor.
// The core side uses the master modport and the coprocessor uses the slave modport.
interface cvxif_copro_responder_if #(
    parameter int XLEN    = 64,
    parameter int IdWidth = 3
);
    logic                 x_issue_valid_i;
    logic [31:0]          x_issue_instr_i;
    logic [IdWidth-1:0]   x_issue_id_i;
    logic [XLEN-1:0]      x_issue_rs1_i;
    logic [XLEN-1:0]      x_issue_rs2_i;
    logic [1:0]           x_issue_rs_valid_i;
    logic                 x_issue_ready_o;
    logic                 x_issue_accept_o;
    logic                 x_issue_writeback_o;

    logic                 x_commit_valid_i;
    logic [IdWidth-1:0]   x_commit_id_i;
    logic                 x_commit_kill_i;

    logic                 x_result_valid_o;
    logic                 x_result_ready_i;
    logic [IdWidth-1:0]   x_result_id_o;
    logic [4:0]           x_result_rd_o;
    logic [XLEN-1:0]      x_result_data_o;
    logic                 x_result_we_o;

    modport master (
        output x_issue_valid_i, x_issue_instr_i, x_issue_id_i, x_issue_rs1_i, x_issue_rs2_i,
               x_issue_rs_valid_i, x_commit_valid_i, x_commit_id_i, x_commit_kill_i,
               x_result_ready_i,
        input  x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o, x_result_valid_o,
               x_result_id_o, x_result_rd_o, x_result_data_o, x_result_we_o
    );

    modport slave (
        input  x_issue_valid_i, x_issue_instr_i, x_issue_id_i, x_issue_rs1_i, x_issue_rs2_i,
               x_issue_rs_valid_i, x_commit_valid_i, x_commit_id_i, x_commit_kill_i,
               x_result_ready_i,
        output x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o, x_result_valid_o,
               x_result_id_o, x_result_rd_o, x_result_data_o, x_result_we_o
    );
endinterface

// File: rtl/cvxif_copro_responder.sv
// Custom-instruction coprocessor: decodes CUS_ADD / CUS_NOP / CUS_ADD_MULTI,
// queues accepted adds in a small FIFO, and retires the head in order once it
// has been committed (or drops it silently when it was killed).
module cvxif_copro_responder #(
    parameter int XLEN    = 64,
    parameter int IdWidth = 3,
    parameter int Depth   = 4
) (
    input logic clk_i,
    input logic rst_i,
    cvxif_copro_responder_if.slave bus
);
    localparam int AW  = $clog2(Depth);
    localparam int NID = 1 << IdWidth;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT_CMT, RESP} state_e;

    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NID-1:0]     cmt_flag_q, cmt_flag_d, kill_flag_q, kill_flag_d;
    logic [IdWidth-1:0] fifo_id_q   [Depth];
    logic [IdWidth-1:0] fifo_id_d   [Depth];
    logic [4:0]         fifo_rd_q   [Depth];
    logic [4:0]         fifo_rd_d   [Depth];
    logic [XLEN-1:0]    fifo_data_q [Depth];
    logic [XLEN-1:0]    fifo_data_d [Depth];
    logic               fifo_multi_q[Depth];
    logic               fifo_multi_d[Depth];

    logic               op_custom, is_add, is_nop, is_multi, rs_ok;
    logic               full_w, empty_w, handshake_w, accept_w, push_w, pop_w, resp_w;
    logic [AW:0]        count_w;
    logic [AW-1:0]      wr_idx, rd_idx, ent_off;
    logic [IdWidth-1:0] head_id;
    logic               head_cmt, head_kill;
    logic [NID-1:0]     pending_w;
    logic               unused_instr_bits;

    // Decode: custom-0 opcode with funct7 zero; funct3 selects the operation.
    assign op_custom = (bus.x_issue_instr_i[6:0] == 7'b0001011) && (bus.x_issue_instr_i[31:25] == 7'd0);
    assign is_add    = op_custom && (bus.x_issue_instr_i[14:12] == 3'b000);
    assign is_nop    = op_custom && (bus.x_issue_instr_i[14:12] == 3'b001);
    assign is_multi  = op_custom && (bus.x_issue_instr_i[14:12] == 3'b010);
    assign rs_ok     = is_nop || ((is_add || is_multi) && (bus.x_issue_rs_valid_i == 2'b11));
    assign unused_instr_bits = ^bus.x_issue_instr_i[24:15];

    assign wr_idx  = wr_ptr_q[AW-1:0];
    assign rd_idx  = rd_ptr_q[AW-1:0];
    assign count_w = wr_ptr_q - rd_ptr_q;
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

    // Issue response is purely combinational; forced low while reset is held.
    assign handshake_w             = bus.x_issue_valid_i && !full_w && !rst_i;
    assign accept_w                = handshake_w && rs_ok;
    assign push_w                  = accept_w && (is_add || is_multi);
    assign bus.x_issue_ready_o     = !full_w;
    assign bus.x_issue_accept_o    = accept_w;
    assign bus.x_issue_writeback_o = push_w;

    // Head commit status includes a commit arriving this very cycle.
    assign head_id   = fifo_id_q[rd_idx];
    assign head_cmt  = cmt_flag_q[head_id] || (bus.x_commit_valid_i && (bus.x_commit_id_i == head_id));
    assign head_kill = kill_flag_q[head_id] ||
                       (bus.x_commit_valid_i && bus.x_commit_kill_i && (bus.x_commit_id_i == head_id));

    assign resp_w               = (state_q == RESP);
    assign bus.x_result_valid_o = resp_w;
    assign bus.x_result_we_o    = resp_w;
    assign bus.x_result_id_o    = resp_w ? head_id : '0;
    assign bus.x_result_rd_o    = resp_w ? fifo_rd_q[rd_idx] : '0;
    assign bus.x_result_data_o  = resp_w ? fifo_data_q[rd_idx] : '0;

    // Head sequencing: latency countdown, commit wait, result hand-off.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop_w   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_w) begin
                    state_d = EXEC;
                    cnt_d   = fifo_multi_q[rd_idx] ? 2'd3 : 2'd0;
                end
            end
            EXEC: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else if (head_kill) begin
                    pop_w   = 1'b1;
                    state_d = IDLE;
                end else if (head_cmt) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT_CMT;
                end
            end
            WAIT_CMT: begin
                if (head_kill) begin
                    pop_w   = 1'b1;
                    state_d = IDLE;
                end else if (head_cmt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.x_result_ready_i) begin
                    pop_w   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // IDs still owning a queue slot after this cycle; commits to any other ID are dropped.
    always_comb begin
        pending_w = '0;
        ent_off   = '0;
        for (int i = 0; i < Depth; i++) begin
            ent_off = AW'(i) - rd_idx;
            if (({1'b0, ent_off} < count_w) && !(pop_w && (ent_off == '0))) begin
                pending_w[fifo_id_q[i]] = 1'b1;
            end
        end
        if (push_w) begin
            pending_w[bus.x_issue_id_i] = 1'b1;
        end
    end

    // Per-ID flags: cleared when the head retires, set by commits to live IDs.
    always_comb begin
        cmt_flag_d  = cmt_flag_q;
        kill_flag_d = kill_flag_q;
        if (pop_w) begin
            cmt_flag_d[head_id]  = 1'b0;
            kill_flag_d[head_id] = 1'b0;
        end
        if (bus.x_commit_valid_i && pending_w[bus.x_commit_id_i]) begin
            cmt_flag_d[bus.x_commit_id_i] = 1'b1;
            if (bus.x_commit_kill_i) begin
                kill_flag_d[bus.x_commit_id_i] = 1'b1;
            end
        end
    end

    // Queue pointers and storage write for the incoming entry.
    always_comb begin
        wr_ptr_d     = push_w ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop_w ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fifo_id_d    = fifo_id_q;
        fifo_rd_d    = fifo_rd_q;
        fifo_data_d  = fifo_data_q;
        fifo_multi_d = fifo_multi_q;
        if (push_w) begin
            fifo_id_d[wr_idx]    = bus.x_issue_id_i;
            fifo_rd_d[wr_idx]    = bus.x_issue_instr_i[11:7];
            fifo_data_d[wr_idx]  = bus.x_issue_rs1_i + bus.x_issue_rs2_i;
            fifo_multi_d[wr_idx] = is_multi;
        end
    end

    // Control state with asynchronous reset; in-flight work is discarded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cmt_flag_q  <= '0;
            kill_flag_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cmt_flag_q  <= cmt_flag_d;
            kill_flag_q <= kill_flag_d;
        end
    end

    // Queue payload; validity is tracked entirely by the pointers.
    always_ff @(posedge clk_i) begin
        fifo_id_q    <= fifo_id_d;
        fifo_rd_q    <= fifo_rd_d;
        fifo_data_q  <= fifo_data_d;
        fifo_multi_q <= fifo_multi_d;
    end
endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Bench for cvxif_copro_responder: directed scenarios followed by random traffic,
// with a result scoreboard drained by an independent monitor.
module tb_cvxif_copro_responder;
    localparam int XLEN = 64;
    localparam int IDW  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cvxif_copro_responder_if #(.XLEN(XLEN), .IdWidth(IDW)) bus();
    cvxif_copro_responder #(.XLEN(XLEN), .IdWidth(IDW), .Depth(4)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } res_t;
    typedef struct packed {
        logic [IDW-1:0] id;
        logic           kill;
    } cmt_t;

    res_t sb[$];
    cmt_t pend[$];
    int   total = 0;
    int   bad   = 0;
    bit   auto_commit = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
        return {f7, 10'h2A5, f3, rd, op};
    endfunction

    // Reference decode: which instructions are taken and which write back.
    function automatic void model_issue(input logic [31:0] instr, input logic [1:0] rsv,
                                        output bit acc, output bit wb);
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        bit custom;
        op = instr[6:0];
        f7 = instr[31:25];
        f3 = instr[14:12];
        custom = (op == 7'h0B) && (f7 == 7'h00);
        wb  = custom && (f3 == 3'd0 || f3 == 3'd2) && (rsv == 2'b11);
        acc = wb || (custom && f3 == 3'd1);
    endfunction

    task automatic drive_pend();
        cmt_t c;
        c = pend.pop_front();
        bus.x_commit_valid_i = 1'b1;
        bus.x_commit_id_i    = c.id;
        bus.x_commit_kill_i  = c.kill;
    endtask

    task automatic end_cycle();
        @(posedge clk);
        #1;
        bus.x_issue_valid_i  = 1'b0;
        bus.x_commit_valid_i = 1'b0;
        bus.x_commit_kill_i  = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [IDW-1:0] id,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [1:0] rsv, input bit cmt, input bit kill, output bit enq);
        bit   exp_acc, exp_wb;
        logic rdy;
        res_t r;
        bus.x_issue_valid_i    = 1'b1;
        bus.x_issue_instr_i    = instr;
        bus.x_issue_id_i       = id;
        bus.x_issue_rs1_i      = a;
        bus.x_issue_rs2_i      = b;
        bus.x_issue_rs_valid_i = rsv;
        bus.x_commit_valid_i   = cmt;
        bus.x_commit_id_i      = id;
        bus.x_commit_kill_i    = kill;
        if (!cmt && auto_commit && pend.size() != 0 && $urandom_range(1, 0) == 1) drive_pend();
        #1;
        rdy = bus.x_issue_ready_o;
        model_issue(instr, rsv, exp_acc, exp_wb);
        exp_acc = exp_acc && rdy;
        exp_wb  = exp_wb && rdy;
        check("issue_accept", bus.x_issue_accept_o, exp_acc);
        check("issue_writeback", bus.x_issue_writeback_o, exp_wb);
        enq = exp_wb;
        if (exp_wb) begin
            r.id   = id;
            r.rd   = instr[11:7];
            r.data = a + b;
            if (!kill) sb.push_back(r);
            if (!cmt) begin
                cmt_t c;
                c.id = id;
                c.kill = kill;
                pend.push_back(c);
            end
        end
        end_cycle();
    endtask

    task automatic watch_no_result(input string name, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            seen = seen | bus.x_result_valid_o;
        end
        check(name, seen, 1'b0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        bus.x_result_ready_i = 1'b1;
        while ((sb.size() != 0 || pend.size() != 0) && n < 400) begin
            if (pend.size() != 0) drive_pend();
            end_cycle();
            n++;
        end
        check({name, "_done"}, sb.size() == 0, 1'b1);
        repeat (8) end_cycle();
        check({name, "_ready"}, bus.x_issue_ready_o, 1'b1);
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.x_result_valid_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got id %0d data %0h, expected no result",
                         bus.x_result_id_o, bus.x_result_data_o);
            end else begin
                check("result_id", bus.x_result_id_o, sb[0].id);
                check("result_rd", bus.x_result_rd_o, sb[0].rd);
                check("result_data", bus.x_result_data_o, sb[0].data);
                check("result_we", bus.x_result_we_o, 1'b1);
                if (bus.x_result_ready_i) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit enq;
        logic [IDW-1:0] id_ctr;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [1:0] rsv;
        logic [XLEN-1:0] a, b;

        bus.x_issue_valid_i    = 1'b1;
        bus.x_issue_instr_i    = mk(7'h00, 3'd0, 5'd1, 7'h0B);
        bus.x_issue_id_i       = '0;
        bus.x_issue_rs1_i      = 64'd1;
        bus.x_issue_rs2_i      = 64'd1;
        bus.x_issue_rs_valid_i = 2'b11;
        bus.x_commit_valid_i   = 1'b0;
        bus.x_commit_id_i      = '0;
        bus.x_commit_kill_i    = 1'b0;
        bus.x_result_ready_i   = 1'b0;

        // Reset state, with a valid supported issue held on the bus.
        repeat (2) @(posedge clk);
        #1;
        check("rst_result_valid", bus.x_result_valid_o, 1'b0);
        check("rst_ready", bus.x_issue_ready_o, 1'b1);
        check("rst_accept", bus.x_issue_accept_o, 1'b0);
        check("rst_result_data", bus.x_result_data_o, 64'd0);
        rst = 1'b0;
        bus.x_issue_valid_i = 1'b0;

        // CUS_ADD committed at issue: result three cycles later.
        issue(mk(7'h00, 3'd0, 5'd5, 7'h0B), 3'd2, 64'h10, 64'h22, 2'b11, 1'b1, 1'b0, enq);
        check("lat_cycle1", bus.x_result_valid_o, 1'b0);
        @(posedge clk); #1;
        check("lat_cycle2", bus.x_result_valid_o, 1'b0);
        @(posedge clk); #1;
        check("lat_cycle3", bus.x_result_valid_o, 1'b1);
        bus.x_result_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.x_result_ready_i = 1'b0;

        // Killed CUS_ADD_MULTI never responds; following op is unaffected.
        issue(mk(7'h00, 3'd2, 5'd3, 7'h0B), 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b11, 1'b1, 1'b1, enq);
        watch_no_result("kill_no_result", 10);
        issue(mk(7'h00, 3'd0, 5'd7, 7'h0B), 3'd4, 64'd5, 64'd6, 2'b11, 1'b1, 1'b0, enq);
        drain("after_kill");

        // Unsupported encodings and missing operands are refused.
        check("unsup_ready", bus.x_issue_ready_o, 1'b1);
        issue(mk(7'h00, 3'd0, 5'd4, 7'h33), 3'd1, 64'd1, 64'd2, 2'b11, 1'b1, 1'b0, enq);
        issue(mk(7'h00, 3'd3, 5'd4, 7'h0B), 3'd1, 64'd1, 64'd2, 2'b11, 1'b1, 1'b0, enq);
        issue(mk(7'h01, 3'd0, 5'd4, 7'h0B), 3'd1, 64'd1, 64'd2, 2'b11, 1'b1, 1'b0, enq);
        issue(mk(7'h00, 3'd0, 5'd4, 7'h0B), 3'd1, 64'd1, 64'd2, 2'b01, 1'b1, 1'b0, enq);
        issue(mk(7'h00, 3'd1, 5'd4, 7'h0B), 3'd1, 64'd1, 64'd2, 2'b00, 1'b1, 1'b0, enq);
        watch_no_result("unsup_no_result", 8);
        check("unsup_ready_after", bus.x_issue_ready_o, 1'b1);

        // Commit before any pending entry is ignored.
        bus.x_commit_valid_i = 1'b1;
        bus.x_commit_id_i    = 3'd6;
        end_cycle();
        issue(mk(7'h00, 3'd0, 5'd9, 7'h0B), 3'd6, 64'd100, 64'd23, 2'b11, 1'b0, 1'b0, enq);
        pend.delete();
        bus.x_result_ready_i = 1'b1;
        watch_no_result("stale_commit_ignored", 8);
        bus.x_commit_valid_i = 1'b1;
        bus.x_commit_id_i    = 3'd6;
        end_cycle();
        drain("late_commit");

        // Back-to-back adds with result path stalled: queue fills at four.
        bus.x_result_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("fill_ready_%0d", k), bus.x_issue_ready_o, (k < 4) ? 1'b1 : 1'b0);
            issue(mk(7'h00, 3'd0, 5'(k + 10), 7'h0B), 3'(k), 64'(k * 7), 64'd1000, 2'b11, 1'b1, 1'b0, enq);
        end
        drain("fill_drain");

        // Reset while a result is being presented.
        bus.x_result_ready_i = 1'b0;
        issue(mk(7'h00, 3'd0, 5'd2, 7'h0B), 3'd1, 64'd8, 64'd9, 2'b11, 1'b1, 1'b0, enq);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("resp_before_rst", bus.x_result_valid_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", bus.x_result_valid_o, 1'b0);
        check("rst_mid_ready", bus.x_issue_ready_o, 1'b1);
        sb.delete();
        pend.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.x_result_ready_i = 1'b1;
        issue(mk(7'h00, 3'd0, 5'd3, 7'h0B), 3'd5, 64'd40, 64'd2, 2'b11, 1'b1, 1'b0, enq);
        check("post_rst_accepted", enq, 1'b1);
        drain("post_rst");

        // Random traffic with random commit timing, kills and result back-pressure.
        auto_commit = 1'b1;
        id_ctr = '0;
        repeat (400) begin
            bus.x_result_ready_i = ($urandom_range(3, 0) != 0);
            if ($urandom_range(4, 0) == 0) begin
                if (pend.size() != 0 && $urandom_range(1, 0) == 1) drive_pend();
                end_cycle();
            end else begin
                op  = ($urandom_range(99, 0) < 85) ? 7'h0B : 7'h33;
                f7  = ($urandom_range(9, 0) == 0) ? 7'h01 : 7'h00;
                f3  = 3'($urandom_range(3, 0));
                rsv = ($urandom_range(4, 0) == 0) ? 2'($urandom_range(2, 0)) : 2'b11;
                a   = ($urandom_range(7, 0) == 0) ? '1 : {$urandom, $urandom};
                b   = {$urandom, $urandom};
                issue(mk(f7, f3, 5'($urandom), op), id_ctr, a, b, rsv,
                      $urandom_range(9, 0) < 6, $urandom_range(3, 0) == 0, enq);
                if (enq) id_ctr = id_ctr + 1'b1;
            end
        end
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
